// File: rtl/rnn_mem_responder.sv
// Memory/input responder for the RNN accelerator: weight/bias/T banks, output bank,
// input FIFO and run sequencer. Define RNN_MEM_ERRCHK_EN to flag and block out-of-range accesses.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; host may access banks
// S_START | ready pulse to the accelerator
// S_WAIT  | waiting for busy to rise, bounded by an 8-cycle timeout
// S_RUN   | accelerator busy; ends on busy falling
// S_DONE  | done pulse; host may access banks
module rnn_mem_responder #(
    parameter int T_MAX    = 16,
    parameter int IN_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mce,
    input  logic [2:0]  msel,
    input  logic [16:0] maddr,
    input  logic [19:0] mdata_w,
    output logic [19:0] mdata_r,
    input  logic        busy,
    input  logic        i_en,
    output logic [31:0] idata,
    output logic        ready,
    input  logic        host_we,
    input  logic        host_re,
    input  logic [2:0]  host_sel,
    input  logic [16:0] host_addr,
    input  logic [19:0] host_wdata,
    output logic [19:0] host_rdata,
    input  logic        in_push,
    input  logic [31:0] in_word,
    input  logic        start,
    output logic        done,
    output logic        err
);

    localparam int OUT_DEPTH = T_MAX * 64;
    localparam int OUT_AW    = $clog2(OUT_DEPTH);
    localparam int IN_AW     = $clog2(IN_DEPTH);
    localparam logic [IN_AW:0] PTR_ONE = 1;

    localparam logic [2:0] SEL_WX  = 3'b000;
    localparam logic [2:0] SEL_BX  = 3'b001;
    localparam logic [2:0] SEL_WH  = 3'b010;
    localparam logic [2:0] SEL_BH  = 3'b011;
    localparam logic [2:0] SEL_T   = 3'b100;
    localparam logic [2:0] SEL_OUT = 3'b101;

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RUN, S_DONE} state_t;

    state_t      state;
    logic [2:0]  wait_cnt;

    logic [19:0] w_x_mem [2048];
    logic [19:0] w_h_mem [4096];
    logic [19:0] b_x_mem [64];
    logic [19:0] b_h_mem [64];
    logic [19:0] out_mem [OUT_DEPTH];
    logic [19:0] t_reg;

    logic [31:0]  fifo_mem [IN_DEPTH];
    logic [IN_AW:0] wr_ptr;
    logic [IN_AW:0] rd_ptr;
    logic         fifo_empty;
    logic         fifo_full;
    logic         do_push;
    logic         do_pop;

    logic         host_ok;
    logic         host_wr;
    logic         acc_wr;
    logic         acc_oor;
    logic         host_oor;
    logic         err_evt;

    function automatic logic [19:0] bank_rd(input logic [2:0] sel, input logic [16:0] a);
        case (sel)
            SEL_WX:  return w_x_mem[a[10:0]];
            SEL_BX:  return b_x_mem[a[5:0]];
            SEL_WH:  return w_h_mem[a[11:0]];
            SEL_BH:  return b_h_mem[a[5:0]];
            SEL_T:   return t_reg;
            SEL_OUT: return out_mem[a[OUT_AW-1:0]];
            default: return 20'h0;
        endcase
    endfunction

`ifdef RNN_MEM_ERRCHK_EN
    function automatic logic addr_oor(input logic [2:0] sel, input logic [16:0] a);
        case (sel)
            SEL_WX:         return a[16:11] != '0;
            SEL_WH:         return a[16:12] != '0;
            SEL_BX, SEL_BH: return a[16:6] != '0;
            SEL_OUT:        return int'(a) >= OUT_DEPTH;
            default:        return 1'b0;
        endcase
    endfunction

    assign acc_oor  = mce && addr_oor(msel, maddr);
    assign host_oor = (host_we || host_re) && addr_oor(host_sel, host_addr);
`else
    assign acc_oor  = 1'b0;
    assign host_oor = 1'b0;
`endif

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[IN_AW] != rd_ptr[IN_AW]) &&
                        (wr_ptr[IN_AW-1:0] == rd_ptr[IN_AW-1:0]);
    assign do_pop     = i_en && !fifo_empty;
    // a pop frees the slot the same cycle, so a push into a full FIFO still lands
    assign do_push    = in_push && (!fifo_full || do_pop);
    assign idata      = fifo_empty ? 32'h0 : fifo_mem[rd_ptr[IN_AW-1:0]];

    assign host_ok = !busy && (state == S_IDLE || state == S_DONE);
    assign host_wr = !reset && host_ok && host_we && !host_oor;
    assign acc_wr  = !reset && mce && (msel == SEL_OUT) && !acc_oor;

    always_comb begin
        err_evt = 1'b0;
        if (in_push && fifo_full && !do_pop)                     err_evt = 1'b1;
        if (i_en && fifo_empty)                                  err_evt = 1'b1;
        if ((host_we || host_re) && !host_ok)                    err_evt = 1'b1;
        if (host_ok && host_oor)                                 err_evt = 1'b1;
        if (acc_oor)                                             err_evt = 1'b1;
        if (state == S_IDLE && start && t_reg == '0)             err_evt = 1'b1;
        if (state == S_WAIT && !busy && wait_cnt == '0)          err_evt = 1'b1;
    end

    // storage survives reset; only writes are suppressed while reset is high
    always_ff @(posedge clk) begin
        if (host_wr) begin
            case (host_sel)
                SEL_WX:  w_x_mem[host_addr[10:0]] <= host_wdata;
                SEL_BX:  b_x_mem[host_addr[5:0]] <= host_wdata;
                SEL_WH:  w_h_mem[host_addr[11:0]] <= host_wdata;
                SEL_BH:  b_h_mem[host_addr[5:0]] <= host_wdata;
                SEL_T:   t_reg <= host_wdata;
                SEL_OUT: out_mem[host_addr[OUT_AW-1:0]] <= host_wdata;
                default: ;
            endcase
        end
        if (acc_wr)
            out_mem[maddr[OUT_AW-1:0]] <= mdata_w;
        if (!reset && do_push)
            fifo_mem[wr_ptr[IN_AW-1:0]] <= in_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mdata_r    <= '0;
            host_rdata <= '0;
            ready      <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;

            if (mce && msel != SEL_OUT)
                mdata_r <= acc_oor ? 20'h0 : bank_rd(msel, maddr);
            // read uses the array before this cycle's host write: pre-write value
            if (host_ok && host_re)
                host_rdata <= host_oor ? 20'h0 : bank_rd(host_sel, host_addr);

            if (err_evt) err <= 1'b1;

            ready <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && t_reg != '0) begin
                        state <= S_START;
                        ready <= 1'b1;
                    end
                end
                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= 3'd7;
                end
                S_WAIT: begin
                    if (busy)
                        state <= S_RUN;
                    else if (wait_cnt == '0)
                        state <= S_IDLE;
                    else
                        wait_cnt <= wait_cnt - 3'd1;
                end
                S_RUN: begin
                    if (!busy) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rnn_mem_responder.sv
// Directed bench for rnn_mem_responder: bank access, input FIFO, run sequencing, reset and errors.
module tb_rnn_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_w;
    logic [19:0] mdata_r;
    logic        busy;
    logic        i_en;
    logic [31:0] idata;
    logic        ready;
    logic        host_we;
    logic        host_re;
    logic [2:0]  host_sel;
    logic [16:0] host_addr;
    logic [19:0] host_wdata;
    logic [19:0] host_rdata;
    logic        in_push;
    logic [31:0] in_word;
    logic        start;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    rnn_mem_responder #(.T_MAX(16), .IN_DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r),
        .busy(busy), .i_en(i_en), .idata(idata), .ready(ready),
        .host_we(host_we), .host_re(host_re), .host_sel(host_sel), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .in_push(in_push), .in_word(in_word), .start(start), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic host_wr(input logic [2:0] sel, input logic [16:0] a, input logic [19:0] d);
        host_we = 1'b1; host_sel = sel; host_addr = a; host_wdata = d;
        tick();
        host_we = 1'b0;
    endtask

    task automatic host_rd(input logic [2:0] sel, input logic [16:0] a);
        host_re = 1'b1; host_sel = sel; host_addr = a;
        tick();
        host_re = 1'b0;
    endtask

    task automatic acc_rd(input logic [2:0] sel, input logic [16:0] a);
        mce = 1'b1; msel = sel; maddr = a;
        tick();
        mce = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        in_push = 1'b1; in_word = w;
        tick();
        in_push = 1'b0;
    endtask

    initial begin
        int n;
        int dpulses;
        reset = 1'b1; mce = 0; msel = 0; maddr = 0; mdata_w = 0; busy = 0; i_en = 0;
        host_we = 0; host_re = 0; host_sel = 0; host_addr = 0; host_wdata = 0;
        in_push = 0; in_word = 0; start = 0;
        tick(); tick();
        reset = 1'b0;
        chk_vec("rst_mdata_r", 32'(mdata_r), 32'h0);
        chk_vec("rst_host_rdata", 32'(host_rdata), 32'h0);
        chk_vec("rst_ready", 32'(ready), 32'h0);
        chk_vec("rst_done", 32'(done), 32'h0);
        chk_vec("rst_err", 32'(err), 32'h0);
        chk_vec("rst_idata", idata, 32'h0);

        // bank reads by the accelerator
        host_wr(3'b010, 17'h000C5, 20'h0ABCD);
        host_wr(3'b000, 17'h00000, 20'h11111);
        host_wr(3'b001, 17'h00005, 20'h22222);
        acc_rd(3'b010, 17'h000C5);
        chk_vec("acc_rd_wh", 32'(mdata_r), 32'h0ABCD);
        tick(); tick();
        chk_vec("mce0_hold", 32'(mdata_r), 32'h0ABCD);
        acc_rd(3'b000, 17'h00800);
        chk_vec("acc_rd_wx_wrap", 32'(mdata_r), 32'h11111);
        chk_vec("wrap_no_err", 32'(err), 32'h0);
        acc_rd(3'b110, 17'h00000);
        chk_vec("acc_rd_sel110", 32'(mdata_r), 32'h0);
        host_rd(3'b001, 17'h00005);
        chk_vec("host_rd_bx", 32'(host_rdata), 32'h22222);

        // simultaneous host write and read returns the old word
        host_we = 1'b1; host_re = 1'b1; host_sel = 3'b001; host_addr = 17'h5; host_wdata = 20'h33333;
        tick();
        host_we = 1'b0; host_re = 1'b0;
        chk_vec("host_rw_old", 32'(host_rdata), 32'h22222);
        host_rd(3'b001, 17'h00005);
        chk_vec("host_rw_new", 32'(host_rdata), 32'h33333);

        // run with input FIFO traffic
        host_wr(3'b100, 17'h0, 20'h2);
        push(32'hDEADBEEF);
        push(32'h12345678);
        chk_vec("fifo_showahead", idata, 32'hDEADBEEF);
        chk_vec("ready_idle", 32'(ready), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_vec("ready_hi", 32'(ready), 32'h1);
        tick();
        chk_vec("ready_one_cycle", 32'(ready), 32'h0);
        busy = 1'b1;
        tick();
        i_en = 1'b1;
        tick();
        chk_vec("idata_2nd", idata, 32'h12345678);
        tick();
        chk_vec("idata_empty", idata, 32'h0);
        chk_vec("err_before_underflow", 32'(err), 32'h0);
        tick();
        i_en = 1'b0;
        chk_vec("err_underflow", 32'(err), 32'h1);
        chk_vec("idata_underflow", idata, 32'h0);
        mce = 1'b1; msel = 3'b101; maddr = {11'd1, 6'd63}; mdata_w = 20'hF0000;
        tick();
        mce = 1'b0;
        dpulses = 0;
        repeat (45) begin
            tick();
            if (done) dpulses++;
        end
        busy = 1'b0;
        tick();
        chk_vec("done_pulse", 32'(done), 32'h1);
        tick();
        chk_vec("done_one_cycle", 32'(done), 32'h0);
        repeat (3) begin
            tick();
            if (done) dpulses++;
        end
        chk_vec("done_no_extra", 32'(dpulses), 32'h0);
        host_rd(3'b101, {11'd1, 6'd63});
        chk_vec("out_bank_rd", 32'(host_rdata), 32'hF0000);

        // host write while busy is dropped
        do_reset();
        chk_vec("err_cleared", 32'(err), 32'h0);
        busy = 1'b1;
        host_wr(3'b010, 17'h000C5, 20'h55555);
        busy = 1'b0;
        chk_vec("err_host_busy", 32'(err), 32'h1);
        host_rd(3'b010, 17'h000C5);
        chk_vec("bank_unchanged", 32'(host_rdata), 32'h0ABCD);

        // reset in the middle of a run
        do_reset();
        push(32'hCAFE0001);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        busy = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        busy = 1'b0;
        chk_vec("midrun_ready", 32'(ready), 32'h0);
        chk_vec("midrun_err", 32'(err), 32'h0);
        chk_vec("midrun_fifo_flushed", idata, 32'h0);
        dpulses = 0;
        repeat (5) begin
            tick();
            if (done) dpulses++;
        end
        chk_vec("midrun_no_done", 32'(dpulses), 32'h0);
        acc_rd(3'b010, 17'h000C5);
        chk_vec("midrun_bank_intact", 32'(mdata_r), 32'h0ABCD);
        host_rd(3'b100, 17'h1F);
        chk_vec("t_retained", 32'(host_rdata), 32'h2);

        // busy never rises: timeout after 8 idle cycles in WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n = 0;
        while (!err && n < 20) begin
            tick();
            n++;
        end
        chk_vec("timeout_cycles", 32'(n), 32'd8);
        chk_vec("timeout_no_done", 32'(done), 32'h0);

        // start with T = 0
        do_reset();
        host_wr(3'b100, 17'h0, 20'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_vec("t0_err", 32'(err), 32'h1);
        chk_vec("t0_no_ready", 32'(ready), 32'h0);

        // FIFO full boundary
        do_reset();
        for (int i = 0; i < 16; i++) push(32'hA000_0000 + 32'(i));
        chk_vec("fifo_full_no_err", 32'(err), 32'h0);
        in_push = 1'b1; in_word = 32'hB000_0000; i_en = 1'b1;
        tick();
        in_push = 1'b0; i_en = 1'b0;
        chk_vec("full_pushpop_head", idata, 32'hA000_0001);
        chk_vec("full_pushpop_err", 32'(err), 32'h0);
        push(32'hC000_0000);
        chk_vec("overflow_err", 32'(err), 32'h1);
        i_en = 1'b1;
        repeat (15) tick();
        i_en = 1'b0;
        chk_vec("fifo_tail_word", idata, 32'hB000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rnn_mem_responder.md
Name: rnn_mem_responder

Overview:
- Responder side of the RNN accelerator's memory and input interface.
- Services the accelerator's mce/msel/maddr/mdata_w accesses from five banks:
  - weights W_x, W_h
  - biases b_x, b_h
  - time-step count
- Stores hidden-state writebacks in an output bank.
- Feeds idata words from a host-loaded FIFO in response to i_en, and sequences a run (ready pulse, busy tracking, done).
- Host port preloads banks and reads results while the accelerator is idle.

Parameters:
- T_MAX, 16, max time steps held in output bank (output depth = T_MAX*64 words).
- IN_DEPTH, 16, input FIFO depth in 32-bit words (power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- mce  in  1  accelerator memory enable.
- msel  in  3  bank select: 000 W_x, 001 b_x, 010 W_h, 011 b_h, 100 T count, 101 output.
- maddr  in  17  accelerator word address.
- mdata_w  in  20  accelerator write data (bank 101 only).
- mdata_r  out  20  read data to accelerator.
- busy  in  1  accelerator busy.
- i_en  in  1  accelerator input request.
- idata  out  32  input word to accelerator.
- ready  out  1  run start pulse.
- host_we  in  1  host write strobe.
- host_re  in  1  host read strobe.
- host_sel  in  3  host bank select (same encoding as msel).
- host_addr  in  17  host address.
- host_wdata  in  20  host write data.
- host_rdata  out  20  host read data.
- in_push  in  1  push in_word into input FIFO.
- in_word  in  32  input FIFO data.
- start  in  1  request a run.
- done  out  1  one-cycle pulse at run end.
- err  out  1  sticky error flag.

Behaviour:
- Bank sizes and addressing:
  - W_x: 2048 words, index maddr[10:0] = {h[5:0], x[4:0]}.
  - W_h: 4096 words, index maddr[11:0] = {row[5:0], col[5:0]}.
  - b_x, b_h: 64 words each, index maddr[5:0].
  - T: single 20-bit register; any address reads it.
  - Output: index maddr[16:0] = {t[10:0], h[5:0]}.
- Accelerator read: in a cycle with mce=1 and msel!=101, mdata_r is registered with the addressed word next cycle (1-cycle latency). With mce=0, mdata_r holds its value. msel 110/111 reads 0.
- Accelerator write: mce=1 and msel=101 writes mdata_w to the output bank at maddr in that cycle; mdata_r unchanged.
- Host access:
  - Honoured only when busy=0 and FSM in IDLE or DONE.
  - host_we writes host_wdata to the selected bank; writing bank 100 sets T.
  - host_re returns the word on host_rdata one cycle later.
  - host_we and host_re together: write takes effect, read returns the pre-write value.
  - Host access while a run is active is dropped and sets err.
- Input FIFO:
  - Show-ahead: idata = head word combinationally, 0 when empty.
  - i_en=1 pops the head the same cycle.
  - in_push while full is dropped and sets err.
  - i_en while empty sets err; idata stays 0.
  - Simultaneous push and pop when full: pop then push, occupancy unchanged.
- FSM:
  - IDLE: start=1 and T!=0 -> START. start with T=0 sets err and stays in IDLE.
  - START: ready=1 for exactly one cycle -> WAIT.
  - WAIT: busy=1 -> RUN. If busy stays 0 for 8 cycles, set err -> IDLE.
  - RUN: busy falling (1->0) -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start outside IDLE is ignored.
- Reset (sync, 1 cycle):
  - FSM IDLE; FIFO empty.
  - Outputs mdata_r=0, host_rdata=0, ready=0, done=0, err=0.
  - Bank contents and T retained.
  - Reset mid-run aborts immediately; no done pulse.

Optional Feature:
- RNN_MEM_ERRCHK_EN defined:
  - Accelerator or host accesses beyond bank depth set err.
  - Out-of-range reads return 0; out-of-range writes are dropped.
  - Also applies to output addresses with t >= T_MAX.
- Undefined:
  - Addresses are truncated modulo bank depth.
  - Out-of-range accesses raise no flag.
  - err is driven only by FIFO, host-collision, start and timeout conditions.

Test Plan:
- Host writes W_h[{6'd3,6'd5}]=20'h0ABCD; accelerator reads mce=1, msel=010, maddr=17'h0C5 -> mdata_r=20'h0ABCD the next cycle.
- Host sets T=2, pushes 2 words 32'hDEADBEEF, 32'h12345678; start -> ready high exactly 1 cycle. i_en pulses -> idata shows DEADBEEF then 12345678; third i_en -> idata=0, err=1.
- Accelerator writes msel=101, maddr={11'd1,6'd63}, mdata_w=20'hF0000; after run, host_re at the same address -> host_rdata=20'hF0000 one cycle later.
- busy 1 for 50 cycles then 0 -> done pulses once, one cycle after the fall; FSM back in IDLE; host access now accepted.
- Host write during busy=1 -> bank unchanged, err=1. Reset mid-run -> ready=0, done never pulses, err=0, bank contents intact.
- With RNN_MEM_ERRCHK_EN, read of msel=000 at maddr=17'h00800 -> mdata_r=0, err=1. Without it, the same read returns W_x[0].
